wb_rr_bus_arbiter: RTL and testbench
====================================

// Module: wb_rr_bus_arbiter
// PURPOSE
//  Two-master Wishbone arbiter and address decoder between the CPU data port (m0) and instruction port (m1).
//  Four slaves sit behind it: SDRAM, UART, GPIO and flash.
//  Round-robin grant, held for a whole bus cycle (cyc high); slave select decoded from addr[31:28].
//  Replaces the generic 8x16 interconnect in the minimal SOPC top level.
// PARAMETERS
//  NSLV        4    number of decoded slaves; region = addr[31:28], legal 0..NSLV-1
//  TMO_CYCLES  255  ack timeout in cycles; used only when WB_ARB_TMO_EN is defined
// PORTS
//  clk          in   1    system clock
//  rst          in   1    asynchronous reset, active-high
//  m0_data_i    in   32   m0 write data
//  m0_addr_i    in   32   m0 address
//  m0_sel_i     in   4    m0 byte selects
//  m0_we_i      in   1    m0 write enable
//  m0_cyc_i     in   1    m0 cycle
//  m0_stb_i     in   1    m0 strobe
//  m0_data_o    out  32   m0 read data
//  m0_ack_o     out  1    m0 acknowledge
//  m0_err_o     out  1    m0 error
//  m1_*         -    -    identical set to m0_* (instruction master)
//  s_data_o     out  32   write data to slaves (shared)
//  s_addr_o     out  32   address to slaves (shared)
//  s_sel_o      out  4    byte selects to slaves (shared)
//  s_we_o       out  1    write enable to slaves (shared)
//  s_cyc_o      out  4    per-slave cycle, one-hot or zero
//  s_stb_o      out  4    per-slave strobe, one-hot or zero
//  s_data_i     in   128  slave read data; slave k on bits [32k+31:32k]
//  s_ack_i      in   4    per-slave acknowledge
//  grant_o      out  2    debug: {m1_owns, m0_owns}
// BEHAVIOUR
//  - Reset: every output is 0, state=IDLE, last_grant=m1, so m0 wins the first tie. Reset is asynchronous and takes effect mid-transfer.
//  - State IDLE
//      - A master requests when its cyc is high.
//      - One requester: grant it.
//      - Both requesting: grant the master that is not last_grant.
//      - Go to OWN_Mx. The grant is registered, so there is 1 cycle of arbitration latency.
//  - State OWN_Mx
//      - Owner's addr/data/sel/we drive the shared slave bus.
//      - s_cyc_o[r] and s_stb_o[r] follow the owner's cyc and stb combinationally; r = addr[31:28].
//      - Owner's ack_o = s_ack_i[r] and data_o = s_data_i[r], both combinational (0 added latency).
//      - The non-owner's ack/err/data are 0 and it waits.
//      - Owner drops cyc: go to IDLE next cycle, last_grant = owner, all s_cyc/s_stb = 0.
//  - The grant stays through back-to-back stb pulses while cyc is held; there is no preemption.
//  - Unmapped region (r >= NSLV) with stb high in OWN_Mx
//      - No slave strobed.
//      - err_o pulses for 1 cycle, the cycle after stb is seen.
//      - A held stb gives a new err pulse every other cycle.
//  - s_ack_i arriving for a slave not currently selected is ignored.
//  - Arbitration uses cyc only; stb does not affect who gets the grant.
// CONFIGURATION
//  - WB_ARB_TMO_EN defined
//      - An 8-bit counter clears on any ack and on stb low, and counts while the owner's stb is high without ack.
//      - At TMO_CYCLES: owner err_o pulses 1 cycle, s_stb_o is forced 0 for that cycle, counter clears.
//      - ack and a timeout in the same cycle: ack wins and no err is given.
//  - WB_ARB_TMO_EN undefined: no counter; a missing ack stalls the owner forever; err_o is only for unmapped addresses.
// TESTING
//  - m0 read 0x2000_0000, GPIO acks on the 2nd cycle
//      -> s_stb_o=4'b0100; m0_ack_o high the same cycle as s_ack_i[2]; m0_data_o = s_data_i[95:64].
//  - m0 and m1 raise cyc together right after reset
//      -> m0 is granted first; after m0 drops cyc, m1 is granted 1 cycle later.
//  - Both masters request continuously for 4 transfers
//      -> grants alternate m0,m1,m0,m1; grant_o is never 2'b11.
//  - m1 accesses 0x5000_0000
//      -> s_stb_o stays 0; m1_err_o is a single-cycle pulse; m1_ack_o stays 0.
//  - rst asserted while m0 owns the bus with stb high
//      -> all outputs 0 in the same cycle; after release m0 wins the tie.
//  - WB_ARB_TMO_EN, TMO_CYCLES=8, UART never acks
//      -> err_o pulses after 8 cycles of stb; with the macro undefined, no err after 1000 cycles.

Source files
------------

// File: rtl/wb_rr_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter with slave decode on addr[31:28].
// Define WB_ARB_TMO_EN to add an ack timeout that errors the owner after TMO_CYCLES.
module wb_rr_bus_arbiter #(
  parameter int unsigned NSLV       = 4,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          m0_data_i,
  input  logic [31:0]          m0_addr_i,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic [31:0]          m0_data_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [31:0]          m1_data_i,
  input  logic [31:0]          m1_addr_i,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic [31:0]          m1_data_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic [31:0]          s_data_o,
  output logic [31:0]          s_addr_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [32*NSLV-1:0]   s_data_i,
  input  logic [NSLV-1:0]      s_ack_i,
  output logic [1:0]           grant_o
);

  typedef enum logic [1:0] {StIdle, StOwnM0, StOwnM1} state_e;

  state_e          state_q;
  logic            last_q;   // 1: m1 was the most recent owner
  logic            err_q;
  logic [1:0]      grant_q;

  logic            owned;
  logic            own_cyc;
  logic            own_stb;
  logic            own_we;
  logic [31:0]     own_addr;
  logic [31:0]     own_data;
  logic [3:0]      own_sel;
  logic [3:0]      region;
  logic            mapped;
  logic [NSLV-1:0] sel;
  logic [31:0]     rdata;
  logic            ack_sel;
  logic            tmo_hit;

  always_comb begin
    owned    = 1'b0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_sel  = '0;
    unique case (state_q)
      StOwnM0: begin
        owned    = 1'b1;
        own_cyc  = m0_cyc_i;
        own_stb  = m0_stb_i;
        own_we   = m0_we_i;
        own_addr = m0_addr_i;
        own_data = m0_data_i;
        own_sel  = m0_sel_i;
      end
      StOwnM1: begin
        owned    = 1'b1;
        own_cyc  = m1_cyc_i;
        own_stb  = m1_stb_i;
        own_we   = m1_we_i;
        own_addr = m1_addr_i;
        own_data = m1_data_i;
        own_sel  = m1_sel_i;
      end
      default: ;
    endcase
  end

  // Slave decode; acks from unselected slaves never reach ack_sel.
  always_comb begin
    region = own_addr[31:28];
    mapped = owned && (32'(region) < NSLV);
    sel    = '0;
    rdata  = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (mapped && (region == 4'(k))) begin
        sel[k] = 1'b1;
        rdata  = s_data_i[32*k +: 32];
      end
    end
    ack_sel = |(sel & s_ack_i);
  end

`ifdef WB_ARB_TMO_EN
  logic [7:0] tmo_q;
  logic [7:0] tmo_d;

  // An ack in the expiry cycle suppresses the timeout.
  always_comb begin
    tmo_hit = owned && own_stb && mapped && !ack_sel && (tmo_q == 8'(TMO_CYCLES));
    tmo_d   = tmo_q + 8'd1;
    if (!owned || !own_stb || !mapped || ack_sel || tmo_hit) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_cycles;
  assign tmo_hit           = 1'b0;
  assign unused_tmo_cycles = ^TMO_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= StOwnM0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= StOwnM1;
            grant_q <= 2'b10;
          end
        end
        StOwnM0, StOwnM1: begin
          if (!own_cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= (state_q == StOwnM1);
          end else begin
            // Unmapped strobe: one-cycle error, re-armed every other cycle while held.
            err_q <= own_stb && !mapped && !err_q;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_addr_o  = own_addr;
    s_data_o  = own_data;
    s_sel_o   = own_sel;
    s_we_o    = own_we;
    s_cyc_o   = own_cyc ? sel : '0;
    s_stb_o   = (own_stb && !tmo_hit) ? sel : '0;
    m0_ack_o  = (state_q == StOwnM0) && ack_sel;
    m0_err_o  = (state_q == StOwnM0) && (err_q || tmo_hit);
    m0_data_o = (state_q == StOwnM0) ? rdata : '0;
    m1_ack_o  = (state_q == StOwnM1) && ack_sel;
    m1_err_o  = (state_q == StOwnM1) && (err_q || tmo_hit);
    m1_data_o = (state_q == StOwnM1) ? rdata : '0;
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_bus_arbiter.sv
// Scoreboard bench for wb_rr_bus_arbiter: directed transfers push expected responses and grants,
// negedge monitors pop and compare. Honours WB_ARB_TMO_EN with TMO_CYCLES = 8.
`timescale 1ns/1ps
module tb_wb_rr_bus_arbiter;

  localparam int unsigned NSLV = 4;
  localparam int unsigned TMO  = 8;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] m_dat  [2];
  logic [31:0] m_addr [2];
  logic [3:0]  m_sel  [2];
  logic        m_we   [2];
  logic        m_cyc  [2];
  logic        m_stb  [2];

  logic [31:0]        m0_data_o, m1_data_o;
  logic               m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0]        s_data_o, s_addr_o;
  logic [3:0]         s_sel_o;
  logic               s_we_o;
  logic [NSLV-1:0]    s_cyc_o, s_stb_o;
  logic [32*NSLV-1:0] s_data_i;
  logic [NSLV-1:0]    s_ack_i;
  logic [1:0]         grant_o;

  logic [NSLV-1:0] ack_q;
  logic [NSLV-1:0] ack_en = '1;
  logic [NSLV-1:0] spur   = '0;

  resp_t       exp_q0[$];
  resp_t       exp_q1[$];
  logic [1:0]  exp_gnt_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc_n = 0;
  int unsigned drop_cyc [2];
  int unsigned gnt_cyc  [2];
  logic [1:0]  gnt_prev = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  wb_rr_bus_arbiter #(
    .NSLV       (NSLV),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_data_i (m_dat[0]),
    .m0_addr_i (m_addr[0]),
    .m0_sel_i  (m_sel[0]),
    .m0_we_i   (m_we[0]),
    .m0_cyc_i  (m_cyc[0]),
    .m0_stb_i  (m_stb[0]),
    .m0_data_o (m0_data_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_data_i (m_dat[1]),
    .m1_addr_i (m_addr[1]),
    .m1_sel_i  (m_sel[1]),
    .m1_we_i   (m_we[1]),
    .m1_cyc_i  (m_cyc[1]),
    .m1_stb_i  (m_stb[1]),
    .m1_data_o (m1_data_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .s_data_o  (s_data_o),
    .s_addr_o  (s_addr_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i),
    .grant_o   (grant_o)
  );

  function automatic logic [31:0] slave_word(input int k, input logic [31:0] a);
    return (32'(k + 1) * 32'h1111_1111) ^ {4'h0, a[27:0]};
  endfunction

  // Slaves: read data derived from the shared address, registered ack one cycle after strobe.
  always_comb begin
    s_data_i = '0;
    for (int k = 0; k < NSLV; k++) s_data_i[32*k +: 32] = slave_word(k, s_addr_o);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_q <= '0;
    else     ack_q <= ack_en & s_cyc_o & s_stb_o & ~ack_q;
  end
  assign s_ack_i = ack_q | spur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic mon(input int m, input logic ack, input logic err, input logic [31:0] d);
    resp_t e;
    int    sz;
    if (!(ack || err)) return;
    sz = (m == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL m%0d_unexpected_resp: got ack=%b err=%b, expected none", m, ack, err);
      return;
    end
    if (m == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    check($sformatf("m%0d_ack_err", m), 64'({ack, err}), 64'({~e.err, e.err}));
    if (e.chk) check($sformatf("m%0d_rdata", m), 64'(d), 64'(e.data));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      gnt_prev = 2'b00;
    end else begin
      mon(0, m0_ack_o, m0_err_o, m0_data_o);
      mon(1, m1_ack_o, m1_err_o, m1_data_o);
      check("grant_not_both", 64'(grant_o == 2'b11), 64'd0);
      if (grant_o != gnt_prev && grant_o != 2'b00) begin
        if (grant_o[1]) gnt_cyc[1] = cyc_n;
        else            gnt_cyc[0] = cyc_n;
        if (exp_gnt_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL grant_unexpected: got %b, expected no new grant", grant_o);
        end else begin
          check("grant_order", 64'(grant_o), 64'(exp_gnt_q.pop_front()));
        end
      end
      gnt_prev = grant_o;
    end
  end

  task automatic chk_outs_zero(input string name);
    check({name, "_ctl"}, 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, grant_o, s_cyc_o,
                              s_stb_o, s_we_o, s_sel_o}), 64'd0);
    check({name, "_data"}, 64'({|m0_data_o, |m1_data_o, |s_data_o, |s_addr_o}), 64'd0);
  endtask

  // One master transfer; called #1 after a posedge.
  task automatic xfer(input int m, input logic [31:0] a, input logic we, input logic keep);
    resp_t           e;
    logic [3:0]      r;
    logic [NSLV-1:0] exp_stb;
    logic            ack, err, done, seen;
    int              n;
    r       = a[31:28];
    exp_stb = '0;
    if (r < NSLV) exp_stb[r] = 1'b1;
    e.err  = (r >= NSLV);
    e.chk  = !we && (r < NSLV);
    e.data = slave_word(int'(r), a);
    if (m == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    m_addr[m] = a;
    m_we[m]   = we;
    m_dat[m]  = ~a;
    m_sel[m]  = we ? 4'b0110 : 4'b1111;
    m_cyc[m]  = 1'b1;
    m_stb[m]  = 1'b1;
    done = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (grant_o[m] && !seen) begin
        seen = 1'b1;
        check("s_stb_sel", 64'(s_stb_o), 64'(exp_stb));
        check("s_addr_data", {s_addr_o, s_data_o}, {a, ~a});
        check("s_ctl", 64'({s_we_o, s_sel_o, s_cyc_o}), 64'({we, m_sel[m], exp_stb}));
      end
      ack  = (m == 0) ? m0_ack_o : m1_ack_o;
      err  = (m == 0) ? m0_err_o : m1_err_o;
      done = ack || err;
      if (ack && r < NSLV) check("ack_same_cycle", 64'(s_ack_i[r]), 64'd1);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL m%0d_xfer_timeout: got no ack/err in 40 cycles, expected a response", m);
      if (m == 0) void'(exp_q0.pop_back());
      else        void'(exp_q1.pop_back());
    end
    @(posedge clk);
    #1;
    m_stb[m] = 1'b0;
    if (!keep) begin
      m_cyc[m]    = 1'b0;
      drop_cyc[m] = cyc_n;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    int n;
    n = 0;
    while (grant_o != g && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(grant_o), 64'(g));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got no finish by 200us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int acks;
    int nstb;
    for (int i = 0; i < 2; i++) begin
      m_dat[i] = '0; m_addr[i] = '0; m_sel[i] = '0;
      m_we[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    end
    #1 chk_outs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous request straight out of reset: m0 first, m1 two edges after m0 drops cyc.
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    fork
      xfer(0, 32'h0000_0100, 1'b0, 1'b0);
      xfer(1, 32'h3000_0200, 1'b0, 1'b0);
    join
    check("m1_grant_latency", 64'(gnt_cyc[1] - drop_cyc[0]), 64'd2);

    // GPIO read.
    exp_gnt_q.push_back(2'b01);
    xfer(0, 32'h2000_0000, 1'b0, 1'b0);

    // Unmapped region from m1.
    exp_gnt_q.push_back(2'b10);
    xfer(1, 32'h5000_0000, 1'b0, 1'b0);

    // Continuous contention alternates owners.
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    fork
      begin
        xfer(0, 32'h0000_1000, 1'b0, 1'b0);
        xfer(0, 32'h2000_0010, 1'b1, 1'b0);
      end
      begin
        xfer(1, 32'h1000_0020, 1'b0, 1'b0);
        xfer(1, 32'h3000_0030, 1'b0, 1'b0);
      end
    join

    // m0 holds cyc across two strobes; m1 must wait.
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    fork
      begin
        xfer(0, 32'h0000_0040, 1'b0, 1'b1);
        xfer(0, 32'h1000_0044, 1'b0, 1'b0);
      end
      begin
        @(posedge clk); #1;
        xfer(1, 32'h2000_0048, 1'b0, 1'b0);
      end
    join

    // Ack from an unselected slave is ignored; then a flash write.
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b01);
    spur = 4'b1000;
    xfer(0, 32'h0000_0010, 1'b0, 1'b0);
    spur = 4'b0000;
    xfer(0, 32'h3000_0004, 1'b1, 1'b0);

    // Asynchronous reset while m0 owns a stalled UART access.
    exp_gnt_q.push_back(2'b01);
    ack_en     = 4'b1101;
    m_addr[0]  = 32'h1000_0040;
    m_we[0]    = 1'b0;
    m_sel[0]   = 4'hF;
    m_cyc[0]   = 1'b1;
    m_stb[0]   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_own", 64'({grant_o, s_stb_o}), 64'({2'b01, 4'b0010}));
    m_cyc[1]  = 1'b1;
    m_stb[1]  = 1'b0;
    m_addr[1] = 32'h0000_0000;
    #2 rst = 1'b1;
    #1 chk_outs_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    wait_grant(2'b01, "post_rst_tie");
    @(posedge clk); #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    wait_grant(2'b10, "post_rst_m1");
    @(posedge clk); #1;
    m_cyc[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // UART never acks.
    exp_gnt_q.push_back(2'b01);
    m_addr[0] = 32'h1000_0000;
    m_cyc[0]  = 1'b1;
    m_stb[0]  = 1'b1;
`ifdef WB_ARB_TMO_EN
    exp_q0.push_back('{err: 1'b1, chk: 1'b0, data: 32'h0});
    nstb = 0;
    errs = 0;
    for (int i = 0; i < 40 && errs == 0; i++) begin
      @(negedge clk);
      if (m0_err_o) errs = 1;
      else if (s_stb_o[1]) nstb++;
    end
    check("tmo_stb_cycles", 64'(nstb), 64'(TMO));
`else
    errs = 0;
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      errs += int'(m0_err_o);
      acks += int'(m0_ack_o);
    end
    check("no_tmo_stall", 64'({errs[15:0], acks[15:0]}), 64'd0);
    nstb = 0;
`endif
    @(posedge clk); #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    ack_en   = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(exp_q0.size() + exp_q1.size() + exp_gnt_q.size()), 64'd0);
    check("idle_outputs", 64'({grant_o, s_cyc_o, s_stb_o}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
